// File: rtl/pio_arb_pkg.sv
// Shared definitions for the PIO token arbiter: default widths, the
// grant-index width helper and the captured-beat record layout.
package pio_arb_pkg;

  localparam int NUM_SRC_DEF = 4;
  localparam int DATA_W_DEF  = 512;

  // Width of an index that can address n sources (at least one bit).
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int IDX_W_DEF = idx_w(NUM_SRC_DEF);

  // One captured beat as presented downstream.
  typedef struct packed {
    logic                  req_valid;
    logic                  ack_valid;
    logic [IDX_W_DEF-1:0]  src;
    logic [DATA_W_DEF-1:0] data;
  } beat_t;

endpackage

// File: rtl/pio_rr_picker.sv
// Combinational round-robin priority picker: finds the first requesting
// source at or after the pointer, wrapping modulo NUM_SRC.
module pio_rr_picker
  import pio_arb_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int IDX_W   = idx_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_SRC-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [2*NUM_SRC-1:0] w_req_dbl;
  logic [NUM_SRC-1:0]   w_rot;
  logic [NUM_SRC-1:0]   w_low;
  logic [2*NUM_SRC-1:0] w_gnt_dbl;

  // Rotate requests so the pointer position sits at bit 0, isolate the
  // lowest set bit, then rotate the one-hot back into source order.
  assign w_req_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot     = w_req_dbl[NUM_SRC-1:0];
  assign w_low     = w_rot & (~w_rot + 1'b1);
  assign w_gnt_dbl = {w_low, w_low} << i_ptr;
  assign o_gnt     = w_gnt_dbl[2*NUM_SRC-1:NUM_SRC];
  assign o_any     = |i_req;

  // One-hot to binary index encoder.
  always_comb begin
    o_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (o_gnt[k]) o_idx = o_idx | IDX_W'(k);
    end
  end

endmodule

// File: rtl/pio_tkn_arbiter.sv
// Round-robin token issuer for PIO request/ack sources. Grants at most one
// single-cycle token per cycle, captures the granted beat into an output
// register and forwards it downstream over a valid/ready handshake.
module pio_tkn_arbiter
  import pio_arb_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int IDX_W   = idx_w(NUM_SRC)
) (
  input  logic                      user_clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        i_req,
  output logic [NUM_SRC-1:0]        o_tkn,
  input  logic [NUM_SRC-1:0]        i_req_valid,
  input  logic [NUM_SRC-1:0]        i_ack_valid,
  input  logic [NUM_SRC*DATA_W-1:0] i_data,
  output logic                      o_valid,
  output logic                      o_req_valid,
  output logic                      o_ack_valid,
  output logic [IDX_W-1:0]          o_src,
  output logic [DATA_W-1:0]         o_data,
  input  logic                      i_tready,
  output logic                      o_err
);

  logic [IDX_W-1:0]   r_ptr;
  logic               r_valid_p1;
  logic               r_req_valid_p1;
  logic               r_ack_valid_p1;
  logic [IDX_W-1:0]   r_src_p1;
  logic [DATA_W-1:0]  r_data_p1;
  logic               r_err;

  logic [NUM_SRC-1:0] w_gnt;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic               w_gnt_en;
  logic               w_sel_rv;
  logic               w_sel_av;
  logic [DATA_W-1:0]  w_sel_data;
  logic [IDX_W-1:0]   w_ptr_nxt;

  pio_rr_picker #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // A token may only be issued when the output register is free or draining.
  assign w_gnt_en  = (!r_valid_p1 || i_tready) && w_any;
  assign o_tkn     = w_gnt_en ? w_gnt : '0;
  assign w_ptr_nxt = (w_idx == IDX_W'(NUM_SRC - 1)) ? '0 : w_idx + 1'b1;

  // Stage p0: AND-OR select of the granted source's beat (grant is one-hot).
  always_comb begin
    w_sel_rv   = 1'b0;
    w_sel_av   = 1'b0;
    w_sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (w_gnt[k]) begin
        w_sel_rv   = w_sel_rv | i_req_valid[k];
        w_sel_av   = w_sel_av | i_ack_valid[k];
        w_sel_data = w_sel_data | i_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Stage p1: pointer, output register and sticky error flag.
  always_ff @(posedge user_clk) begin
    if (reset) begin
      r_ptr          <= '0;
      r_valid_p1     <= 1'b0;
      r_req_valid_p1 <= 1'b0;
      r_ack_valid_p1 <= 1'b0;
      r_src_p1       <= '0;
      r_data_p1      <= '0;
      r_err          <= 1'b0;
    end else begin
      if (w_gnt_en) begin
        r_ptr          <= w_ptr_nxt;
        r_valid_p1     <= 1'b1;
        r_req_valid_p1 <= w_sel_rv;
        r_ack_valid_p1 <= w_sel_av;
        r_src_p1       <= w_idx;
        r_data_p1      <= w_sel_data;
        // A beat must be exactly one of request or ack.
        if (w_sel_rv == w_sel_av) r_err <= 1'b1;
      end else if (r_valid_p1 && i_tready) begin
        r_valid_p1 <= 1'b0;
      end
    end
  end

  assign o_valid     = r_valid_p1;
  assign o_req_valid = r_req_valid_p1;
  assign o_ack_valid = r_ack_valid_p1;
  assign o_src       = r_src_p1;
  assign o_data      = r_data_p1;
  assign o_err       = r_err;

endmodule

// File: tb/tb_pio_tkn_arbiter.sv
// Self-checking bench for pio_tkn_arbiter with a behavioural reference model.
module tb_pio_tkn_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int IW = 2;

  logic              user_clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      i_req = '0;
  logic [N-1:0]      o_tkn;
  logic [N-1:0]      i_req_valid = '0;
  logic [N-1:0]      i_ack_valid = '0;
  logic [N*DW-1:0]   i_data = '0;
  logic              o_valid;
  logic              o_req_valid;
  logic              o_ack_valid;
  logic [IW-1:0]     o_src;
  logic [DW-1:0]     o_data;
  logic              i_tready = 1'b1;
  logic              o_err;

  pio_tkn_arbiter #(.NUM_SRC(N), .DATA_W(DW), .IDX_W(IW)) dut (
    .user_clk    (user_clk),
    .reset       (reset),
    .i_req       (i_req),
    .o_tkn       (o_tkn),
    .i_req_valid (i_req_valid),
    .i_ack_valid (i_ack_valid),
    .i_data      (i_data),
    .o_valid     (o_valid),
    .o_req_valid (o_req_valid),
    .o_ack_valid (o_ack_valid),
    .o_src       (o_src),
    .o_data      (o_data),
    .i_tready    (i_tready),
    .o_err       (o_err)
  );

  always #5 user_clk = ~user_clk;

  // Reference model state.
  int            m_ptr = 0;
  int            m_g = -1;
  logic          m_valid = 1'b0, m_rv = 1'b0, m_av = 1'b0, m_err = 1'b0;
  logic [IW-1:0] m_src = '0;
  logic [DW-1:0] m_data = '0;
  logic [N-1:0]  exp_tkn = '0;

  int checks = 0;
  int passes = 0;

  // Which source the rules say gets the token this cycle (-1 for none).
  function automatic int model_pick();
    int k;
    if (m_valid && !i_tready) return -1;
    for (int off = 0; off < N; off++) begin
      k = (m_ptr + off) % N;
      if (i_req[k]) return k;
    end
    return -1;
  endfunction

  // Apply inputs at the falling edge and compute the expected token.
  task automatic drive(input logic [N-1:0] req, input logic [N-1:0] rv,
                       input logic [N-1:0] av, input logic tr);
    @(negedge user_clk);
    i_req = req; i_req_valid = rv; i_ack_valid = av; i_tready = tr;
    for (int k = 0; k < N; k++) i_data[k*DW +: DW] = {$urandom, $urandom};
    m_g = model_pick();
    exp_tkn = (m_g < 0) ? '0 : (N'(1) << m_g);
    #1;
  endtask

  // Advance one rising edge and update the model accordingly.
  task automatic tick();
    @(posedge user_clk);
    if (reset) begin
      m_ptr = 0; m_valid = 0; m_rv = 0; m_av = 0; m_err = 0; m_src = '0; m_data = '0;
    end else if (m_g >= 0) begin
      m_valid = 1'b1;
      m_rv    = i_req_valid[m_g];
      m_av    = i_ack_valid[m_g];
      m_src   = IW'(m_g);
      m_data  = i_data[m_g*DW +: DW];
      if (m_rv == m_av) m_err = 1'b1;
      m_ptr   = (m_g + 1) % N;
    end else if (m_valid && i_tready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    drive('0, '0, '0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [N-1:0] rnd_rv();
    return N'($urandom);
  endfunction

  task automatic test_reset();
    do_reset();
    drive('0, '0, '0, 1'b1);
    checks++;
    if ({o_valid, o_req_valid, o_ack_valid, o_src, o_err, o_data, o_tkn} !== '0)
      $display("FAIL reset_state: got v=%b rv=%b av=%b src=%0d err=%b data=%h tkn=%b, need all zero",
               o_valid, o_req_valid, o_ack_valid, o_src, o_err, o_data, o_tkn);
    else passes++;
  endtask

  task automatic test_single();
    do_reset();
    drive(4'b0001, 4'b0000, 4'b0001, 1'b1);
    i_data[0 +: DW] = {8{8'hA5}};
    #1;
    checks++;
    if (o_tkn !== 4'b0001) $display("FAIL single_tkn: o_tkn=%b need 0001", o_tkn);
    else passes++;
    tick();
    checks++;
    if ({o_valid, o_ack_valid, o_req_valid, o_src, o_data} !== {1'b1, 1'b1, 1'b0, 2'd0, {8{8'hA5}}})
      $display("FAIL single_beat: v=%b av=%b rv=%b src=%0d data=%h need 1 1 0 0 a5..", o_valid,
               o_ack_valid, o_req_valid, o_src, o_data);
    else passes++;
    // Pointer moved to 1: with all requesting, source 1 is next.
    drive(4'b1111, 4'b1010, 4'b0101, 1'b1);
    checks++;
    if (o_tkn !== 4'b0010) $display("FAIL single_ptr: o_tkn=%b need 0010", o_tkn);
    else passes++;
    tick();
  endtask

  task automatic test_fairness();
    int beats;
    beats = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(4'b1111, 4'b0011, 4'b1100, 1'b1);
      checks++;
      if (o_tkn !== (N'(1) << (i % 4)) || o_tkn !== exp_tkn)
        $display("FAIL fair_tkn[%0d]: o_tkn=%b need %b", i, o_tkn, N'(1) << (i % 4));
      else passes++;
      tick();
      if (o_valid && o_src == IW'(i % 4)) beats++;
    end
    checks++;
    if (beats !== 8) $display("FAIL fair_beats: got %0d beats need 8", beats);
    else passes++;
  endtask

  task automatic test_wrap();
    do_reset();
    drive(4'b0100, 4'b0100, 4'b0000, 1'b1);
    tick();
    drive(4'b0101, 4'b0001, 4'b0100, 1'b1);
    checks++;
    if (o_tkn !== 4'b0001) $display("FAIL wrap_first: o_tkn=%b need 0001", o_tkn);
    else passes++;
    tick();
    drive(4'b0101, 4'b0001, 4'b0100, 1'b1);
    checks++;
    if (o_tkn !== 4'b0100) $display("FAIL wrap_second: o_tkn=%b need 0100", o_tkn);
    else passes++;
    tick();
    checks++;
    if ({o_valid, o_src, o_data} !== {1'b1, 2'd2, m_data})
      $display("FAIL wrap_beat: v=%b src=%0d data=%h need 1 2 %h", o_valid, o_src, o_data, m_data);
    else passes++;
  endtask

  task automatic test_stall();
    do_reset();
    drive(4'b1111, 4'b1111, 4'b0000, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 4'b1111, 4'b0000, 1'b0);
      checks++;
      if (o_tkn !== 4'b0000) $display("FAIL stall_tkn[%0d]: o_tkn=%b need 0000", i, o_tkn);
      else passes++;
      tick();
      checks++;
      if ({o_valid, o_src, o_data} !== {1'b1, 2'd0, m_data})
        $display("FAIL stall_hold[%0d]: v=%b src=%0d data=%h need 1 0 %h", i, o_valid, o_src,
                 o_data, m_data);
      else passes++;
    end
    drive(4'b1111, 4'b1111, 4'b0000, 1'b1);
    checks++;
    if (o_tkn !== 4'b0010) $display("FAIL stall_release: o_tkn=%b need 0010", o_tkn);
    else passes++;
    tick();
    checks++;
    if ({o_valid, o_src, o_data} !== {1'b1, 2'd1, m_data})
      $display("FAIL stall_next: v=%b src=%0d data=%h need 1 1 %h", o_valid, o_src, o_data, m_data);
    else passes++;
  endtask

  task automatic test_error();
    logic [N-1:0] rv;
    do_reset();
    drive(4'b0100, 4'b0000, 4'b0000, 1'b1);
    tick();
    checks++;
    if (o_err !== 1'b1) $display("FAIL err_set: o_err=%b need 1", o_err);
    else passes++;
    for (int i = 0; i < 10; i++) begin
      rv = rnd_rv();
      drive(4'b1111, rv, ~rv, 1'b1);
      tick();
    end
    checks++;
    if (o_err !== 1'b1 || m_err !== 1'b1) $display("FAIL err_sticky: o_err=%b need 1", o_err);
    else passes++;
    do_reset();
    checks++;
    if (o_err !== 1'b0) $display("FAIL err_clear: o_err=%b need 0", o_err);
    else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(4'b0001, 4'b0001, 4'b0000, 1'b1);
    tick();
    drive(4'b0010, 4'b0000, 4'b0010, 1'b0);
    tick();
    drive(4'b0010, 4'b0000, 4'b0010, 1'b1);
    tick();
    drive(4'b1111, 4'b0000, 4'b0000, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({o_valid, o_err} !== 2'b00) $display("FAIL rstmid_state: v=%b err=%b need 0 0", o_valid, o_err);
    else passes++;
    drive(4'b1111, 4'b0101, 4'b1010, 1'b1);
    checks++;
    if (o_tkn !== 4'b0001) $display("FAIL rstmid_first: o_tkn=%b need 0001", o_tkn);
    else passes++;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] rv, av;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rv = rnd_rv();
      av = ($urandom_range(0, 15) == 0) ? rv : ~rv;
      drive(N'($urandom), rv, av, $urandom_range(0, 3) != 0);
      checks++;
      if (o_tkn !== exp_tkn) $display("FAIL rand_tkn[%0d]: o_tkn=%b need %b", i, o_tkn, exp_tkn);
      else passes++;
      tick();
      checks++;
      if ({o_valid, o_req_valid, o_ack_valid, o_src, o_err} !== {m_valid, m_rv, m_av, m_src, m_err}
          || (m_valid && o_data !== m_data))
        $display("FAIL rand_out[%0d]: v=%b rv=%b av=%b src=%0d err=%b data=%h need %b %b %b %0d %b %h",
                 i, o_valid, o_req_valid, o_ack_valid, o_src, o_err, o_data,
                 m_valid, m_rv, m_av, m_src, m_err, m_data);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_stall();
    test_error();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
